uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles in WAIT_BUSY before abort; legal range 1..65535.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 req  input  4  per-requester byte request; bit i = requester i.
REQ-005 req_data  input  32  byte of requester i on bits [8i+7:8i].
REQ-006 req_lock  input  4  requester i asks to keep the grant for its next byte.
REQ-007 req_ack  output  4  one-cycle pulse: byte of requester i accepted.
REQ-008 grant  output  4  one-hot owner of the transmitter; 0 when idle.
REQ-009 tx_start  output  1  one-cycle start strobe to the UART transmitter.
REQ-010 tx_data  output  8  byte to the UART transmitter; valid while tx_start is high and held until the next capture.
REQ-011 tx_busy  input  1  busy flag from the UART transmitter.
REQ-012 err_timeout  output  1  one-cycle pulse: tx_busy never rose after tx_start.

Function
REQ-013 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-014 IDLE, no eligible req: stay IDLE, grant=0, tx_start=0.
REQ-015 IDLE, eligible req, edge T: capture winner's byte into tx_data, set grant one-hot, pulse req_ack of winner, go LAUNCH; tx_start=1, req_ack and grant visible in cycle T+1.
REQ-016 Arbitration round-robin: search order rr_ptr, rr_ptr+1, ... mod 4; after a grant, rr_ptr = winner+1 mod 4; rr_ptr resets to 0.
REQ-017 Lock: if req_lock[winner]=1 at capture, lock_owner=winner; while lock held only lock_owner is eligible in IDLE.
REQ-018 Lock release: capture from lock_owner with req_lock=0, or lock_owner's req=0 while IDLE; release in IDLE with another req pending allows that req to win in the same cycle.
REQ-019 LAUNCH lasts exactly one cycle (tx_start=1); next state WAIT_BUSY with timeout counter=0.
REQ-020 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; else counter increments; counter reaching TIMEOUT-1 with tx_busy=0 -> pulse err_timeout, grant=0, clear lock, go IDLE.
REQ-021 WAIT_DONE: tx_busy=0 -> grant=0, go IDLE; earliest next capture on the following cycle.
REQ-022 req held high after ack is not re-accepted until IDLE; requester updates req_data no later than the cycle after its ack.
REQ-023 req deasserted before ack: request dropped, no ack; a captured byte is always transmitted or timed out, never withdrawn.
REQ-024 Simultaneous req on all four: exactly one ack per capture; four bytes complete in rr order, none starved.
REQ-025 tx_start, req_ack, err_timeout never high for more than one consecutive cycle; req_ack and grant are 0 or one-hot.

Reset
REQ-026 While reset=1: state=IDLE, grant=0, req_ack=0, tx_start=0, tx_data=8'h00, err_timeout=0, rr_ptr=0, lock cleared, counter=0.
REQ-027 Reset mid-transfer takes effect without a clock edge; first capture possible on the first edge after reset deasserts.

Verification
REQ-028 req=4'b0001, byte 8'hA5 -> T+1: tx_start=1, tx_data=8'hA5, req_ack=4'b0001, grant=4'b0001; grant=0 after tx_busy falls.
REQ-029 req=4'b1111 held, bytes 11/22/33/44 -> transmit order 11,22,33,44; second pass starts again with requester 0.
REQ-030 Requester 2 with req_lock=1 for 3 bytes, requester 0 also requesting -> three bytes of requester 2 back to back, then requester 0.
REQ-031 tx_busy tied 0, TIMEOUT=16 -> err_timeout pulses exactly once, 17 cycles after tx_start, then IDLE, grant=0.
REQ-032 reset asserted during WAIT_DONE -> all outputs at reset values immediately; after release req=4'b0100 wins first.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Four-requester round-robin arbiter in front of a single UART transmitter.
// In IDLE it picks one pending byte, strobes it into the transmitter, and
// then follows the transmitter's busy handshake until the byte is done. If
// busy never rises, the transfer is aborted with a timeout pulse.
//
// Parameters
//   TIMEOUT      cycles allowed in WAIT_BUSY before abort (1..65535)
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   req[3:0]     per-requester byte request
//   req_data     requester i byte on bits [8i+7:8i]
//   req_lock     requester i wants to keep the grant for its next byte
//   req_ack      one-cycle pulse, byte of requester i accepted
//   grant        one-hot owner of the transmitter, 0 when idle
//   tx_start     one-cycle start strobe to the transmitter
//   tx_data      byte to the transmitter, held until the next capture
//   tx_busy      busy flag from the transmitter
//   err_timeout  one-cycle pulse, tx_busy never rose after tx_start
module uart_tx_arb #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_lock,
    output logic [3:0]  req_ack,
    output logic [3:0]  grant,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [1:0]  rr_ptr_q;
    logic        lock_valid_q;
    logic [1:0]  lock_owner_q;
    logic [15:0] cnt_q;
    logic [3:0]  req_ack_q;
    logic [3:0]  grant_q;
    logic        tx_start_q;
    logic [7:0]  tx_data_q;
    logic        err_q;

    // Split the packed request bus into one byte lane per requester.
    logic [7:0] lane_byte [4];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Winner selection for the IDLE state. A held lock restricts the
    // eligible set to the lock owner; if the owner has dropped its request
    // the lock is void and everybody competes in this same cycle.
    logic       lock_hold;
    logic [3:0] elig;
    logic [1:0] cand;
    logic       win_found_d;
    logic [1:0] win_idx_d;
    logic [3:0] win_onehot_d;

    always_comb begin
        lock_hold    = lock_valid_q && req[lock_owner_q];
        elig         = lock_hold ? (req & (4'b0001 << lock_owner_q)) : req;
        cand         = rr_ptr_q;
        win_found_d  = 1'b0;
        win_idx_d    = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!win_found_d && elig[cand]) begin
                win_found_d = 1'b1;
                win_idx_d   = cand;
            end
        end
        win_onehot_d = 4'b0001 << win_idx_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 2'd0;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 2'd0;
            cnt_q        <= 16'd0;
            req_ack_q    <= 4'd0;
            grant_q      <= 4'd0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            err_q        <= 1'b0;
        end else begin
            // Pulse outputs default low so they never last two cycles.
            tx_start_q <= 1'b0;
            req_ack_q  <= 4'd0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (lock_valid_q && !req[lock_owner_q]) begin
                        lock_valid_q <= 1'b0;
                    end
                    if (win_found_d) begin
                        tx_data_q    <= lane_byte[win_idx_d];
                        grant_q      <= win_onehot_d;
                        req_ack_q    <= win_onehot_d;
                        tx_start_q   <= 1'b1;
                        rr_ptr_q     <= win_idx_d + 2'd1;
                        // Capturing with req_lock low releases any lock.
                        lock_valid_q <= req_lock[win_idx_d];
                        lock_owner_q <= win_idx_d;
                        state_q      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt_q   <= 16'd0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q        <= 1'b1;
                        grant_q      <= 4'd0;
                        lock_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        grant_q <= 4'd0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ack     = req_ack_q;
    assign grant       = grant_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign err_timeout = err_q;

endmodule
